// File: rtl/host_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : host_pkt_tx
//  Purpose  : Frames a byte stream from user logic into packets of the form
//             SOF, LEN, LEN payload bytes, CHK and writes them into the
//             HostIoComm upload FIFO. Each byte write is a single-cycle add
//             strobe followed by one dead cycle so the FIFO flags can settle.
//             CHK is chosen so that (LEN + payload + CHK) mod 256 == 0.
//  Ports    : clk_i      - clock
//             reset_i    - asynchronous active-low reset
//             start_i    - packet request, sampled only when idle
//             len_i      - payload length captured with start_i
//             data_i     - payload byte, qualified by dataVld_i
//             dataVld_i  - payload byte valid
//             dataRdy_o  - payload byte consumed this cycle
//             add_o      - upload FIFO write strobe
//             data_o     - upload FIFO write data
//             upFull_i   - upload FIFO full
//             busy_o     - packet in progress
//             done_o     - one-cycle pulse once the packet is complete
//             err_o      - one-cycle pulse when start_i is rejected
//  Revision : 1.0 - initial release
// ============================================================================
module host_pkt_tx #(
  parameter int unsigned MAX_LEN_G = 16,
  parameter logic [7:0]  SOF_G     = 8'hA5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] len_i,
  input  logic [7:0] data_i,
  input  logic       dataVld_i,
  output logic       dataRdy_o,
  output logic       add_o,
  output logic [7:0] data_o,
  input  logic       upFull_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  state_t     r_state,   w_stateNxt;
  state_t     r_resume,  w_resumeNxt;   // state entered when GAP ends
  logic [7:0] r_lenCap,  w_lenCapNxt;
  logic [7:0] r_remain,  w_remainNxt;
  logic [7:0] r_chk,     w_chkNxt;
  logic [7:0] r_data,    w_dataNxt;
  logic       r_add,     w_addNxt;
  logic       r_busy,    w_busyNxt;
  logic       r_done,    w_doneNxt;
  logic       r_err,     w_errNxt;
  logic       r_chkSent, w_chkSentNxt;  // CHK already written, finish on return
  logic       w_dataRdy;
  logic       w_lenOk;

  assign w_lenOk = (len_i != 8'd0) && ({24'd0, len_i} <= MAX_LEN_G);

  always_comb begin
    w_stateNxt   = r_state;
    w_resumeNxt  = r_resume;
    w_lenCapNxt  = r_lenCap;
    w_remainNxt  = r_remain;
    w_chkNxt     = r_chk;
    w_dataNxt    = r_data;
    w_addNxt     = 1'b0;
    w_busyNxt    = r_busy;
    w_doneNxt    = 1'b0;
    w_errNxt     = 1'b0;
    w_chkSentNxt = r_chkSent;
    w_dataRdy    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (w_lenOk) begin
            w_lenCapNxt  = len_i;
            w_remainNxt  = len_i;
            w_chkNxt     = 8'd0;
            w_chkSentNxt = 1'b0;
            w_busyNxt    = 1'b1;
            w_stateNxt   = ST_SOF;
          end else begin
            w_errNxt = 1'b1;
          end
        end
      end
      ST_SOF: begin
        if (!upFull_i) begin
          w_addNxt    = 1'b1;
          w_dataNxt   = SOF_G;
          w_resumeNxt = ST_LEN;
          w_stateNxt  = ST_GAP;
        end
      end
      ST_LEN: begin
        if (!upFull_i) begin
          w_addNxt    = 1'b1;
          w_dataNxt   = r_lenCap;
          w_chkNxt    = r_chk + r_lenCap;
          w_resumeNxt = ST_PAY;
          w_stateNxt  = ST_GAP;
        end
      end
      ST_PAY: begin
        w_dataRdy = dataVld_i && !upFull_i;
        if (w_dataRdy) begin
          w_addNxt    = 1'b1;
          w_dataNxt   = data_i;
          w_chkNxt    = r_chk + data_i;
          w_remainNxt = r_remain - 8'd1;
          w_resumeNxt = (r_remain != 8'd1) ? ST_PAY : ST_CHK;
          w_stateNxt  = ST_GAP;
        end
      end
      ST_CHK: begin
        // Second visit (after the CHK byte's dead cycle) closes the packet.
        if (r_chkSent) begin
          w_doneNxt  = 1'b1;
          w_busyNxt  = 1'b0;
          w_stateNxt = ST_IDLE;
        end else if (!upFull_i) begin
          w_addNxt     = 1'b1;
          w_dataNxt    = 8'd0 - r_chk;
          w_chkSentNxt = 1'b1;
          w_resumeNxt  = ST_CHK;
          w_stateNxt   = ST_GAP;
        end
      end
      ST_GAP: begin
        w_stateNxt = r_resume;
      end
      default: begin
        w_stateNxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= ST_IDLE;
      r_resume  <= ST_IDLE;
      r_lenCap  <= 8'd0;
      r_remain  <= 8'd0;
      r_chk     <= 8'd0;
      r_data    <= 8'd0;
      r_add     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_chkSent <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_resume  <= w_resumeNxt;
      r_lenCap  <= w_lenCapNxt;
      r_remain  <= w_remainNxt;
      r_chk     <= w_chkNxt;
      r_data    <= w_dataNxt;
      r_add     <= w_addNxt;
      r_busy    <= w_busyNxt;
      r_done    <= w_doneNxt;
      r_err     <= w_errNxt;
      r_chkSent <= w_chkSentNxt;
    end
  end

  assign dataRdy_o = w_dataRdy;
  assign add_o     = r_add;
  assign data_o    = r_data;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_host_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_host_pkt_tx
//  Purpose  : Self-checking bench for host_pkt_tx. A table of packets with
//             hand-computed checksums, hand-written multi-cycle sequences
//             (latency, backpressure, payload stall, mid-packet reset) and
//             randomized packets checked against a packet-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_host_pkt_tx;

  localparam logic [7:0] SOF = 8'hA5;

  logic       clk_i = 1'b0;
  logic       reset_i, start_i, dataVld_i, upFull_i;
  logic [7:0] len_i, data_i;
  logic       dataRdy_o, add_o, busy_o, done_o, err_o;
  logic [7:0] data_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  host_pkt_tx #(.MAX_LEN_G(16), .SOF_G(8'hA5)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .len_i    (len_i),
    .data_i   (data_i),
    .dataVld_i(dataVld_i),
    .dataRdy_o(dataRdy_o),
    .add_o    (add_o),
    .data_o   (data_o),
    .upFull_i (upFull_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- output monitor ----------------
  logic [7:0] gotQ[$];
  int         addCyc[$];
  int         doneCnt = 0, errCnt = 0, doneCyc = 0;
  int         b2b = 0, busyBad = 0;
  logic       prevAdd = 1'b0;

  always @(negedge clk_i) begin
    if (add_o) begin
      gotQ.push_back(data_o);
      addCyc.push_back(cyc);
      if (!busy_o) busyBad++;
    end
    if (add_o && prevAdd) b2b++;
    prevAdd = add_o;
    if (done_o) begin doneCnt++; doneCyc = cyc; end
    if (err_o) errCnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clearMon();
    gotQ.delete();
    addCyc.delete();
    doneCnt = 0;
    errCnt  = 0;
  endtask

  // Packet-level reference: checksum byte makes LEN + payload + CHK == 0 mod 256.
  function automatic logic [7:0] modelChk(input int len, input logic [7:0] pay[$]);
    int s = len;
    foreach (pay[i]) s += int'(pay[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic buildExp(input int len, input logic [7:0] pay[$], input logic [7:0] chkByte,
                          output logic [7:0] exp[$]);
    exp.delete();
    exp.push_back(SOF);
    exp.push_back(8'(len));
    foreach (pay[i]) exp.push_back(pay[i]);
    exp.push_back(chkByte);
  endtask

  task automatic verifyPkt(input string name, input logic [7:0] exp[$]);
    chk({name, " nbytes"}, gotQ.size(), exp.size());
    for (int i = 0; i < exp.size() && i < gotQ.size(); i++)
      chk($sformatf("%s byte%0d", name, i), gotQ[i], exp[i]);
    chk({name, " done count"}, doneCnt, 1);
    chk({name, " err count"}, errCnt, 0);
  endtask

  // Drives one packet. Optional scripted windows: upFull_i high for n in
  // [fullFrom, fullFrom+fullLen), dataVld_i low for n in [vldFrom, vldFrom+vldLen).
  // pokeAt pulses start_i with an invalid length while the packet is busy.
  task automatic runPkt(input string name, input int len, input logic [7:0] pay[$],
                        input int vldPct, input int fullPct, input int pokeAt,
                        input int fullFrom, input int fullLen,
                        input int vldFrom, input int vldLen,
                        output int startCyc);
    int  idx = 0;
    int  n   = 0;
    bit  seenDone = 0;
    bit  vOff;
    clearMon();
    @(posedge clk_i); #1;
    startCyc  = cyc;
    start_i   = 1'b1;
    len_i     = 8'(len);
    dataVld_i = 1'b0;
    upFull_i  = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    while (n < 3000) begin
      vOff      = (n >= vldFrom) && (n < vldFrom + vldLen);
      start_i   = (n == pokeAt);
      len_i     = (n == pokeAt) ? 8'd0 : len_i;
      dataVld_i = (idx < pay.size()) && !vOff && ($urandom_range(99) < vldPct);
      data_i    = (idx < pay.size()) ? pay[idx] : 8'($urandom);
      upFull_i  = ((n >= fullFrom) && (n < fullFrom + fullLen)) || ($urandom_range(99) < fullPct);
      @(negedge clk_i);
      if (vOff) begin
        chk($sformatf("%s stall add n%0d", name, n), add_o, 1'b0);
        chk($sformatf("%s stall rdy n%0d", name, n), dataRdy_o, 1'b0);
      end
      if (dataVld_i && dataRdy_o) idx++;
      if (done_o) begin
        chk({name, " busy low at done"}, busy_o, 1'b0);
        seenDone = 1;
        break;
      end
      @(posedge clk_i); #1;
      n++;
    end
    start_i   = 1'b0;
    dataVld_i = 1'b0;
    upFull_i  = 1'b0;
    chk({name, " completed in budget"}, seenDone, 1'b1);
    @(posedge clk_i); #1;
  endtask

  task automatic tryReject(input string name, input int len);
    clearMon();
    @(posedge clk_i); #1;
    start_i = 1'b1;
    len_i   = 8'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    chk({name, " err pulses"}, errCnt, 1);
    chk({name, " no add"}, gotQ.size(), 0);
    chk({name, " not busy"}, busy_o, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    bit         expErr;
    logic [7:0] expChk;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] pay[$];
    logic [7:0] exp[$];
    int         sc, n;
    int         len;

    vecs.push_back('{3,   8'h01, 8'h01, 1'b0, 8'hF7});
    vecs.push_back('{2,   8'hFF, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{2,   8'h10, 8'h10, 1'b0, 8'hCE});
    vecs.push_back('{1,   8'h55, 8'h00, 1'b0, 8'hAA});
    vecs.push_back('{1,   8'h00, 8'h00, 1'b0, 8'hFF});
    vecs.push_back('{16,  8'h00, 8'h01, 1'b0, 8'h78});
    vecs.push_back('{0,   8'h00, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{17,  8'h00, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{255, 8'h00, 8'h00, 1'b1, 8'h00});

    reset_i = 1'b0; start_i = 1'b0; len_i = 8'd0; data_i = 8'd0;
    dataVld_i = 1'b1; upFull_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset add_o", add_o, 1'b0);
    chk("reset data_o", data_o, 8'h00);
    chk("reset busy_o", busy_o, 1'b0);
    chk("reset done_o", done_o, 1'b0);
    chk("reset err_o", err_o, 1'b0);
    chk("reset dataRdy_o", dataRdy_o, 1'b0);
    @(posedge clk_i); #1;
    reset_i   = 1'b1;
    dataVld_i = 1'b0;

    // Basic packet with latency checks and an ignored start while busy.
    pay = '{8'h01, 8'h02, 8'h03};
    runPkt("basic", 3, pay, 100, 0, 3, -1, 0, -1, 0, sc);
    buildExp(3, pay, 8'hF7, exp);
    verifyPkt("basic", exp);
    if (addCyc.size() == 6) begin
      chk("basic first add latency", addCyc[0] - sc, 2);
      chk("basic done latency", doneCyc - addCyc[0], 12);
      for (int i = 1; i < 6; i++)
        chk($sformatf("basic spacing%0d", i), addCyc[i] - addCyc[i-1], 2);
    end else begin
      chk("basic add stamps", addCyc.size(), 6);
    end

    // Backpressure on the LEN emit.
    runPkt("bp", 3, pay, 100, 0, -1, 2, 5, -1, 0, sc);
    verifyPkt("bp", exp);
    if (addCyc.size() >= 2) chk("bp LEN delay", addCyc[1] - addCyc[0], 7);

    // Payload stall before the second byte.
    pay = '{8'h10, 8'h20};
    runPkt("stall", 2, pay, 100, 0, -1, -1, 0, 6, 4, sc);
    buildExp(2, pay, 8'hCE, exp);
    verifyPkt("stall", exp);
    if (addCyc.size() >= 4) chk("stall gap", addCyc[3] - addCyc[2], 6);

    // Table-driven vectors.
    foreach (vecs[v]) begin
      if (vecs[v].expErr) begin
        tryReject($sformatf("vec%0d reject", v), vecs[v].len);
      end else begin
        pay.delete();
        for (int i = 0; i < vecs[v].len; i++)
          pay.push_back(8'(vecs[v].base + 8'(i) * vecs[v].step));
        runPkt($sformatf("vec%0d", v), vecs[v].len, pay, 100, 0, -1, -1, 0, -1, 0, sc);
        buildExp(vecs[v].len, pay, vecs[v].expChk, exp);
        verifyPkt($sformatf("vec%0d", v), exp);
      end
    end

    // Reset in the middle of a 4-byte payload.
    clearMon();
    @(posedge clk_i); #1;
    start_i = 1'b1; len_i = 8'd4; dataVld_i = 1'b1; data_i = 8'h11; upFull_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    while (gotQ.size() < 3 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("rst reached PAY", n < 50, 1'b1);
    #1;
    chk("rst pre dataRdy", dataRdy_o, 1'b1);
    chk("rst pre busy", busy_o, 1'b1);
    reset_i = 1'b0;
    #1;
    chk("rst add_o", add_o, 1'b0);
    chk("rst busy_o", busy_o, 1'b0);
    chk("rst dataRdy_o", dataRdy_o, 1'b0);
    chk("rst data_o", data_o, 8'h00);
    dataVld_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst no resume", gotQ.size(), 3);
    pay = '{8'h55};
    runPkt("post rst", 1, pay, 100, 0, -1, -1, 0, -1, 0, sc);
    buildExp(1, pay, 8'hAA, exp);
    verifyPkt("post rst", exp);

    // Randomized packets against the packet-level model.
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(0, 20);
      if (len == 0 || len > 16) begin
        tryReject($sformatf("rnd%0d reject", r), len);
      end else begin
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
        runPkt($sformatf("rnd%0d", r), len, pay, $urandom_range(50, 100),
               $urandom_range(0, 40), $urandom_range(0, 5), -1, 0, -1, 0, sc);
        buildExp(len, pay, modelChk(len, pay), exp);
        verifyPkt($sformatf("rnd%0d", r), exp);
      end
    end

    chk("add never back to back", b2b, 0);
    chk("add only while busy", busyBad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
